// File: rtl/mega_mux_of_destiny.sv
// Eight-input WIDTH-bit selector built as a three-level tree of gate-level 2:1 muxes.
// Define MEGA_MUX_REG_OUT_EN to register O (one cycle latency, synchronous reset); default is combinational.
module mega_mux_of_destiny #(
   parameter int unsigned WIDTH = 32
) (
   output logic [WIDTH-1:0] O,
   input  logic [2:0]       S,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic [WIDTH-1:0] I2,
   input  logic [WIDTH-1:0] I3,
   input  logic [WIDTH-1:0] I4,
   input  logic [WIDTH-1:0] I5,
   input  logic [WIDTH-1:0] I6,
   input  logic [WIDTH-1:0] I7,
   input  logic             clk,
   input  logic             reset
);

   // AND/OR 2:1 mux; an X select is not masked, so it propagates into the result.
   function automatic logic [WIDTH-1:0] mux2(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             sel);
      return (a & ~{WIDTH{sel}}) | (b & {WIDTH{sel}});
   endfunction

   logic [WIDTH-1:0] lvl1_c [4];
   logic [WIDTH-1:0] lvl2_c [2];
   logic [WIDTH-1:0] sel_c;

   assign lvl1_c[0] = mux2(I0, I1, S[0]);
   assign lvl1_c[1] = mux2(I2, I3, S[0]);
   assign lvl1_c[2] = mux2(I4, I5, S[0]);
   assign lvl1_c[3] = mux2(I6, I7, S[0]);

   assign lvl2_c[0] = mux2(lvl1_c[0], lvl1_c[1], S[1]);
   assign lvl2_c[1] = mux2(lvl1_c[2], lvl1_c[3], S[1]);

   assign sel_c     = mux2(lvl2_c[0], lvl2_c[1], S[2]);

`ifdef MEGA_MUX_REG_OUT_EN
   // Output register; reset wins over the selected value.
   always_ff @(posedge clk) begin
      if (reset) begin
         O <= '0;
      end else begin
         O <= sel_c;
      end
   end
`else
   assign O = sel_c;

   // clk and reset exist only for port compatibility in this build.
   logic unused_ctl;
   assign unused_ctl = clk ^ reset;
`endif

endmodule

// File: tb/tb_mega_mux_of_destiny.sv
// Directed self-checking bench for mega_mux_of_destiny (both builds via MEGA_MUX_REG_OUT_EN, plus a WIDTH=8 instance).
module tb_mega_mux_of_destiny;

   logic        clk;
   logic        reset;
   logic [2:0]  s;
   logic [31:0] i_v [8];
   logic [31:0] o;
   logic [2:0]  s8;
   logic [7:0]  i8_v [8];
   logic [7:0]  o8;

   int n_cmp;
   int n_err;

   mega_mux_of_destiny #(.WIDTH(32)) dut (
      .O(o), .S(s),
      .I0(i_v[0]), .I1(i_v[1]), .I2(i_v[2]), .I3(i_v[3]),
      .I4(i_v[4]), .I5(i_v[5]), .I6(i_v[6]), .I7(i_v[7]),
      .clk(clk), .reset(reset)
   );

   mega_mux_of_destiny #(.WIDTH(8)) dut8 (
      .O(o8), .S(s8),
      .I0(i8_v[0]), .I1(i8_v[1]), .I2(i8_v[2]), .I3(i8_v[3]),
      .I4(i8_v[4]), .I5(i8_v[5]), .I6(i8_v[6]), .I7(i8_v[7]),
      .clk(clk), .reset(reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Let outputs reflect current inputs: one edge in the registered build, propagation otherwise.
   task automatic settle();
`ifdef MEGA_MUX_REG_OUT_EN
      @(posedge clk);
      #1;
`else
      #1;
`endif
   endtask

   task automatic test_reset();
      for (int k = 0; k < 8; k++) i_v[k] = 32'(1) << k;
      s     = 3'd2;
      reset = 1'b1;
      @(posedge clk);
      #1;
`ifdef MEGA_MUX_REG_OUT_EN
      n_cmp++;
      if (o !== 32'h0) begin
         n_err++;
         $display("FAIL reset_zero: got %h expected %h", o, 32'h0);
      end
      // Inputs change after the reset edge: O must hold zero until the next edge.
      reset = 1'b0;
      s     = 3'd3;
      i_v[3] = 32'h12345678;
      #1;
      n_cmp++;
      if (o !== 32'h0) begin
         n_err++;
         $display("FAIL reset_hold_before_edge: got %h expected %h", o, 32'h0);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (o !== 32'h12345678) begin
         n_err++;
         $display("FAIL reset_first_load: got %h expected %h", o, 32'h12345678);
      end
`else
      n_cmp++;
      if (o !== 32'h4) begin
         n_err++;
         $display("FAIL reset_no_effect: got %h expected %h", o, 32'h4);
      end
      reset = 1'b0;
`endif
   endtask

   task automatic test_one_hot_sweep();
      logic [31:0] exp;
      for (int k = 0; k < 8; k++) i_v[k] = 32'(1) << k;
      for (int k = 0; k < 8; k++) begin
         s = 3'(k);
         settle();
         exp = 32'(1) << k;
         n_cmp++;
         if (o !== exp) begin
            n_err++;
            $display("FAIL one_hot_s%0d: got %h expected %h", k, o, exp);
         end
      end
   endtask

   task automatic test_follow();
      for (int k = 0; k < 8; k++) i_v[k] = 32'(1) << k;
      s = 3'd5;
      settle();
      n_cmp++;
      if (o !== 32'h00000020) begin
         n_err++;
         $display("FAIL follow_initial: got %h expected %h", o, 32'h00000020);
      end
      i_v[5] = 32'hFFFFFFFF;
      settle();
      n_cmp++;
      if (o !== 32'hFFFFFFFF) begin
         n_err++;
         $display("FAIL follow_i5: got %h expected %h", o, 32'hFFFFFFFF);
      end
      i_v[4] = 32'hDEADBEEF;
      settle();
      n_cmp++;
      if (o !== 32'hFFFFFFFF) begin
         n_err++;
         $display("FAIL follow_i4_no_leak: got %h expected %h", o, 32'hFFFFFFFF);
      end
   endtask

   task automatic test_no_leak();
      // Each unselected input driven to the complement of the selected one.
      for (int sel = 0; sel < 8; sel++) begin
         for (int k = 0; k < 8; k++) i_v[k] = 32'h3C3C_0FF0;
         i_v[sel] = 32'hC3C3_F00F;
         s = 3'(sel);
         settle();
         n_cmp++;
         if (o !== 32'hC3C3_F00F) begin
            n_err++;
            $display("FAIL no_leak_s%0d: got %h expected %h", sel, o, 32'hC3C3_F00F);
         end
      end
   endtask

   task automatic test_all_equal();
      for (int k = 0; k < 8; k++) i_v[k] = 32'hA5A5A5A5;
      for (int k = 0; k < 8; k++) begin
         s = 3'(k);
         settle();
         n_cmp++;
         if (o !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL all_equal_s%0d: got %h expected %h", k, o, 32'hA5A5A5A5);
         end
      end
`ifndef MEGA_MUX_REG_OUT_EN
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (o !== 32'hA5A5A5A5) begin
         n_err++;
         $display("FAIL all_equal_reset_toggle: got %h expected %h", o, 32'hA5A5A5A5);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
`endif
   endtask

`ifdef MEGA_MUX_REG_OUT_EN
   task automatic test_mid_reset();
      s      = 3'd7;
      i_v[7] = 32'hCAFEF00D;
      settle();
      n_cmp++;
      if (o !== 32'hCAFEF00D) begin
         n_err++;
         $display("FAIL mid_reset_running: got %h expected %h", o, 32'hCAFEF00D);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (o !== 32'h0) begin
         n_err++;
         $display("FAIL mid_reset_zero: got %h expected %h", o, 32'h0);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (o !== 32'hCAFEF00D) begin
         n_err++;
         $display("FAIL mid_reset_reload: got %h expected %h", o, 32'hCAFEF00D);
      end
   endtask
`endif

   task automatic test_width8();
      for (int k = 0; k < 8; k++) i8_v[k] = 8'(1) << k;
      s8 = 3'd6;
      settle();
      n_cmp++;
      if (o8 !== 8'h40) begin
         n_err++;
         $display("FAIL width8_s6: got %h expected %h", o8, 8'h40);
      end
      s8 = 3'd7;
      settle();
      n_cmp++;
      if (o8 !== 8'h80) begin
         n_err++;
         $display("FAIL width8_s7: got %h expected %h", o8, 8'h80);
      end
      s8 = 3'd0;
      settle();
      n_cmp++;
      if (o8 !== 8'h01) begin
         n_err++;
         $display("FAIL width8_s0: got %h expected %h", o8, 8'h01);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      s     = 3'd0;
      s8    = 3'd0;
      for (int k = 0; k < 8; k++) begin
         i_v[k]  = '0;
         i8_v[k] = '0;
      end
      @(negedge clk);
      test_reset();
      test_one_hot_sweep();
      test_follow();
      test_no_leak();
      test_all_equal();
`ifdef MEGA_MUX_REG_OUT_EN
      test_mid_reset();
`endif
      test_width8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mega_mux_of_destiny.md
MEGA_MUX_OF_DESTINY -- requirements
Module: mega_mux_of_destiny

Interface
REQ-001 Parameter: WIDTH, default 32, data width of every data input and of the output.
REQ-002 Port: clk  input  1  single system clock; rising edge active.
REQ-003 Port: reset  input  1  reset, synchronous, active-high.
REQ-004 Port: O  output  WIDTH  selected data output.
REQ-005 Port: S  input  3  select code, unsigned 0..7.
REQ-006 Ports: I0..I7  input  WIDTH each  data inputs 0 through 7.
REQ-007 Positional port order SHALL be O, S, I0, I1, I2, I3, I4, I5, I6, I7, clk, reset, so that existing ten-port positional instantiations bind correctly.
REQ-008 One clock domain; reset is synchronous and active-high.

Function
REQ-009 Selected value SHALL be I[S]: S=0 -> I0, S=1 -> I1, ... S=7 -> I7, bit-exact across all WIDTH bits.
REQ-010 Selection SHALL be built as a three-level tree of 2:1 muxes: level 1 on S[0] over pairs (I0,I1)(I2,I3)(I4,I5)(I6,I7); level 2 on S[1]; level 3 on S[2].
REQ-011 Each 2:1 mux bit SHALL be gate-level: out = (a AND NOT sel) OR (b AND sel).
REQ-012 No data input SHALL leak to O when not selected; every output bit depends only on S and the selected input bit.
REQ-013 Any X or Z on S SHALL NOT be masked; X on S may propagate X to O (no default substitution).
REQ-014 All inputs equal -> O equals that value regardless of S.
REQ-015 Output path (combinational or registered) SHALL be set by REQ-019/REQ-020; the select tree is identical in both builds.
REQ-016 No internal state other than the optional output register; no handshake; O is valid whenever S and I are stable.

Reset
REQ-017 Registered build: reset high at a rising clk edge SHALL load O to all zeros that edge, overriding the mux result; reset asserted mid-operation takes effect at the next edge; the first edge after reset deasserts loads I[S].
REQ-018 Combinational build: clk and reset SHALL be functionally unused (no effect on O); the ports remain present.

Configuration
REQ-019 Macro MEGA_MUX_REG_OUT_EN defined: O SHALL be a WIDTH-bit register loaded with I[S] on every rising clk edge, latency exactly one cycle, reset per REQ-017.
REQ-020 Macro MEGA_MUX_REG_OUT_EN undefined (default): O SHALL be purely combinational, zero cycle latency, following any change on S or I within propagation delay.

Verification
REQ-021 Default build, I0..I7 = 1,2,4,8,16,32,64,128; step S 0..7 with settle time -> O = 1,2,4,8,16,32,64,128 respectively, checked with case inequality (no X/Z).
REQ-022 Default build, S=5, I5 changed 0x00000020 -> 0xFFFFFFFF while other inputs held -> O follows to 0xFFFFFFFF; changing I4 to 0xDEADBEEF leaves O unchanged.
REQ-023 Default build, all inputs 0xA5A5A5A5, sweep S 0..7 -> O = 0xA5A5A5A5 for every S; toggle reset and clk -> O unchanged.
REQ-024 MEGA_MUX_REG_OUT_EN build, reset high one edge -> O = 0; release, S=3, I3=0x12345678 -> O = 0 before the next edge, 0x12345678 after it.
REQ-025 MEGA_MUX_REG_OUT_EN build, S=7, I7=0xCAFEF00D running; assert reset for one edge -> O = 0 that edge; deassert -> O = 0xCAFEF00D one edge later.
REQ-026 WIDTH=8 instance, I0..I7 = 0x01..0x80, S=6 -> O = 0x40; top-bit check S=7 -> O = 0x80.
